// File: rtl/lpm_abs_pipe.sv
// lpm_abs_pipe: multi-channel pipelined two's-complement absolute value.
// Stage 1 computes |x| and the most-negative flag for every channel; later
// stages only delay the result. A combinational ready chain runs back from
// out_ready, so empty stages always accept and bubbles collapse.
// ovf_sticky accumulates overflow per channel, counted on output transfers.
module lpm_abs_pipe #(
  parameter string lpm_type     = "lpm_abs_pipe",
  parameter int    lpm_width    = 8,
  parameter int    lpm_channels = 1,
  parameter int    lpm_pipeline = 2,
  parameter int    lpm_saturate = 0,
  parameter string lpm_hint     = "UNUSED"
) (
  input  logic                              clock,
  input  logic                              aclr_n,
  input  logic [lpm_channels*lpm_width-1:0] data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [lpm_channels*lpm_width-1:0] result,
  output logic [lpm_channels-1:0]           overflow,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [lpm_channels-1:0]           ovf_sticky,
  input  logic                              sticky_clr
);

  localparam int W = lpm_width;
  localparam int C = lpm_channels;
  localparam int N = lpm_pipeline;

  // Most-negative code; built by shifting so that W=1 needs no zero-width replication.
  localparam logic [W-1:0] MIN_NEG = W'(1) << (W - 1);

  if (lpm_width < 1 || lpm_channels < 1 || lpm_pipeline < 1) begin : g_bad_param
    $error("lpm_abs_pipe: lpm_width, lpm_channels and lpm_pipeline must all be >= 1");
  end

  if (lpm_type == "" || lpm_hint == "") begin : g_empty_str
    $warning("lpm_abs_pipe: lpm_type/lpm_hint should not be empty strings");
  end

  logic [N-1:0]   vld_q;
  logic [N-1:0]   vld_d;
  logic [C*W-1:0] res_q [N];
  logic [C*W-1:0] res_d [N];
  logic [C-1:0]   ovf_q [N];
  logic [C-1:0]   ovf_d [N];
  logic [C-1:0]   sticky_q;
  logic [C-1:0]   sticky_d;
  logic [N-1:0]   load;
  logic [C*W-1:0] s1_res;
  logic [C-1:0]   s1_ovf;

  // Magnitude of one sample; the most-negative code wraps to itself or
  // saturates to the largest positive value depending on lpm_saturate.
  function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
    logic [W-1:0] r;
    if (x == MIN_NEG)
      r = (lpm_saturate != 0) ? ~MIN_NEG : MIN_NEG;
    else if (x[W-1])
      r = ~x + W'(1);
    else
      r = x;
    return r;
  endfunction

  // True when the sample has no representable positive magnitude.
  function automatic logic is_min_neg(input logic signed [W-1:0] x);
    return (x == MIN_NEG);
  endfunction

  // Stage-1 arithmetic for every channel
  always_comb begin
    s1_res = '0;
    s1_ovf = '0;
    for (int c = 0; c < C; c++) begin
      s1_res[c*W +: W] = abs_sat($signed(data[c*W +: W]));
      s1_ovf[c]        = is_min_neg($signed(data[c*W +: W]));
    end
  end

  // Ready chain: a stage loads when it is empty or its successor loads
  always_comb begin
    load        = '0;
    load[N-1]   = !vld_q[N-1] || out_ready;
    for (int k = N - 2; k >= 0; k--)
      load[k] = !vld_q[k] || load[k+1];
  end

  // Next state of the stage registers and the sticky flags
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < N; k++) begin
      res_d[k] = res_q[k];
      ovf_d[k] = ovf_q[k];
    end
    // ---- input -> S1
    if (load[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        res_d[0] = s1_res;
        ovf_d[0] = s1_ovf;
      end
    end
    // ---- S(k) -> S(k+1); payload only moves when the source holds a sample
    for (int k = 1; k < N; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          res_d[k] = res_q[k-1];
          ovf_d[k] = ovf_q[k-1];
        end
      end
    end
    // ---- sticky: a set on this transfer wins over a simultaneous clear
    sticky_d = sticky_q & ~{C{sticky_clr}};
    if (vld_q[N-1] && out_ready)
      sticky_d = sticky_d | ovf_q[N-1];
  end

  // State registers; reset empties the pipe and clears all outputs
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      vld_q    <= '0;
      sticky_q <= '0;
      for (int k = 0; k < N; k++) begin
        res_q[k] <= '0;
        ovf_q[k] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      sticky_q <= sticky_d;
      for (int k = 0; k < N; k++) begin
        res_q[k] <= res_d[k];
        ovf_q[k] <= ovf_d[k];
      end
    end
  end

  assign in_ready   = load[0];
  assign out_valid  = vld_q[N-1];
  assign result     = res_q[N-1];
  assign overflow   = ovf_q[N-1];
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_lpm_abs_pipe.sv
// Scoreboard bench for lpm_abs_pipe. Six instances cover the parameter
// corners: A (W8,C1,N2,wrap), B (W8,C1,N3,sat), C/D (W4,C4,N1 wrap/sat),
// E/F (W1,C2,N2 wrap/sat). Drivers push expected values on input transfer;
// negedge monitors pop and compare on output transfer.
module tb_lpm_abs_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A
  logic [7:0] a_data, a_res;
  logic       a_iv, a_ir, a_ovf, a_ov, a_ordy, a_st, a_sc;
  // ---------------- instance B
  logic [7:0] b_data, b_res;
  logic       b_iv, b_ir, b_ovf, b_ov, b_ordy, b_ordy_m, b_rand, rnd, b_st, b_sc;
  // ---------------- instances C/D
  logic [15:0] x_data, c_res, d_res;
  logic        x_iv, x_ordy, x_sc, c_ir, d_ir, c_ov, d_ov;
  logic [3:0]  c_ovf, d_ovf, c_st, d_st;
  // ---------------- instances E/F
  logic [1:0] y_data, e_res, f_res, e_ovf, f_ovf, e_st, f_st;
  logic       y_iv, y_ordy, y_sc, e_ir, f_ir, e_ov, f_ov;

  assign b_ordy = b_rand ? rnd : b_ordy_m;

  lpm_abs_pipe #(.lpm_width(8), .lpm_channels(1), .lpm_pipeline(2), .lpm_saturate(0)) u_a (
    .clock(clk), .aclr_n(rst_n), .data(a_data), .in_valid(a_iv), .in_ready(a_ir),
    .result(a_res), .overflow(a_ovf), .out_valid(a_ov), .out_ready(a_ordy),
    .ovf_sticky(a_st), .sticky_clr(a_sc));
  lpm_abs_pipe #(.lpm_width(8), .lpm_channels(1), .lpm_pipeline(3), .lpm_saturate(1)) u_b (
    .clock(clk), .aclr_n(rst_n), .data(b_data), .in_valid(b_iv), .in_ready(b_ir),
    .result(b_res), .overflow(b_ovf), .out_valid(b_ov), .out_ready(b_ordy),
    .ovf_sticky(b_st), .sticky_clr(b_sc));
  lpm_abs_pipe #(.lpm_width(4), .lpm_channels(4), .lpm_pipeline(1), .lpm_saturate(0)) u_c (
    .clock(clk), .aclr_n(rst_n), .data(x_data), .in_valid(x_iv), .in_ready(c_ir),
    .result(c_res), .overflow(c_ovf), .out_valid(c_ov), .out_ready(x_ordy),
    .ovf_sticky(c_st), .sticky_clr(x_sc));
  lpm_abs_pipe #(.lpm_width(4), .lpm_channels(4), .lpm_pipeline(1), .lpm_saturate(1)) u_d (
    .clock(clk), .aclr_n(rst_n), .data(x_data), .in_valid(x_iv), .in_ready(d_ir),
    .result(d_res), .overflow(d_ovf), .out_valid(d_ov), .out_ready(x_ordy),
    .ovf_sticky(d_st), .sticky_clr(x_sc));
  lpm_abs_pipe #(.lpm_width(1), .lpm_channels(2), .lpm_pipeline(2), .lpm_saturate(0)) u_e (
    .clock(clk), .aclr_n(rst_n), .data(y_data), .in_valid(y_iv), .in_ready(e_ir),
    .result(e_res), .overflow(e_ovf), .out_valid(e_ov), .out_ready(y_ordy),
    .ovf_sticky(e_st), .sticky_clr(y_sc));
  lpm_abs_pipe #(.lpm_width(1), .lpm_channels(2), .lpm_pipeline(2), .lpm_saturate(1)) u_f (
    .clock(clk), .aclr_n(rst_n), .data(y_data), .in_valid(y_iv), .in_ready(f_ir),
    .result(f_res), .overflow(f_ovf), .out_valid(f_ov), .out_ready(y_ordy),
    .ovf_sticky(f_st), .sticky_clr(y_sc));

  // Expected {result[15:0], overflow[3:0]} per instance
  logic [19:0] qa[$], qb[$], qc[$], qd[$], qe[$], qf[$];
  int          qa_t[$];

  function automatic logic [19:0] pk(input logic [15:0] r, input logic [3:0] o);
    return {r, o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Free-running coin for random backpressure on B
  initial begin
    rnd = 1'b1;
    forever begin
      @(posedge clk);
      #2 rnd = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitors
  always @(negedge clk) begin
    if (rst_n && a_ov && a_ordy) begin
      if (qa.size() == 0) chk("a_spurious_output", 1, 0);
      else begin
        chk("a_result", pk({8'h0, a_res}, {3'b0, a_ovf}), qa.pop_front());
        chk("a_latency", cyc - qa_t.pop_front(), 2);
      end
    end
  end

  int         b_occ = 0;
  logic       b_prev_stall = 1'b0;
  logic [7:0] b_prev_res = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_occ = 0;
      b_prev_stall = 1'b0;
    end else begin
      if (b_prev_stall) begin
        chk("b_hold_valid", b_ov, 1);
        chk("b_hold_result", b_res, b_prev_res);
      end
      chk("b_in_ready", b_ir, !(b_occ == 3 && !b_ordy));
      if (b_ov && b_ordy) begin
        if (qb.size() == 0) chk("b_spurious_output", 1, 0);
        else chk("b_result", pk({8'h0, b_res}, {3'b0, b_ovf}), qb.pop_front());
      end
      if (b_iv && b_ir) b_occ++;
      if (b_ov && b_ordy) b_occ--;
      b_prev_stall = b_ov && !b_ordy;
      b_prev_res   = b_res;
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_ov && x_ordy) begin
      if (qc.size() == 0) chk("c_spurious_output", 1, 0);
      else chk("c_result", pk(c_res, c_ovf), qc.pop_front());
    end
    if (rst_n && d_ov && x_ordy) begin
      if (qd.size() == 0) chk("d_spurious_output", 1, 0);
      else chk("d_result", pk(d_res, d_ovf), qd.pop_front());
    end
    if (rst_n && e_ov && y_ordy) begin
      if (qe.size() == 0) chk("e_spurious_output", 1, 0);
      else chk("e_result", pk({14'h0, e_res}, {2'b0, e_ovf}), qe.pop_front());
    end
    if (rst_n && f_ov && y_ordy) begin
      if (qf.size() == 0) chk("f_spurious_output", 1, 0);
      else chk("f_result", pk({14'h0, f_res}, {2'b0, f_ovf}), qf.pop_front());
    end
  end

  // ---------------- drivers
  task automatic send_a(input logic [7:0] d, input logic [7:0] er, input logic eo);
    int n = 0;
    a_data = d;
    a_iv   = 1'b1;
    @(negedge clk);
    while (!a_ir && n < 200) begin @(negedge clk); n++; end
    if (a_ir) begin
      qa.push_back(pk({8'h0, er}, {3'b0, eo}));
      qa_t.push_back(cyc);
    end else chk("a_send_timeout", 0, 1);
    @(posedge clk);
    #1 a_iv = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic [7:0] er, input logic eo);
    int n = 0;
    b_data = d;
    b_iv   = 1'b1;
    @(negedge clk);
    while (!b_ir && n < 200) begin @(negedge clk); n++; end
    if (b_ir) qb.push_back(pk({8'h0, er}, {3'b0, eo}));
    else chk("b_send_timeout", 0, 1);
    @(posedge clk);
    #1 b_iv = 1'b0;
  endtask

  task automatic send_x(input logic [15:0] d, input logic [15:0] ew, input logic [15:0] es,
                        input logic [3:0] eo);
    x_data = d;
    x_iv   = 1'b1;
    @(negedge clk);
    chk("c_in_ready", c_ir, 1);
    chk("d_in_ready", d_ir, 1);
    qc.push_back(pk(ew, eo));
    qd.push_back(pk(es, eo));
    @(posedge clk);
    #1 x_iv = 1'b0;
  endtask

  task automatic send_y(input logic [1:0] d, input logic [1:0] ew, input logic [1:0] es,
                        input logic [1:0] eo);
    y_data = d;
    y_iv   = 1'b1;
    @(negedge clk);
    chk("e_in_ready", e_ir, 1);
    chk("f_in_ready", f_ir, 1);
    qe.push_back(pk({14'h0, ew}, {2'b0, eo}));
    qf.push_back(pk({14'h0, es}, {2'b0, eo}));
    @(posedge clk);
    #1 y_iv = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((qa.size() + qb.size() + qc.size() + qd.size() + qe.size() + qf.size()) != 0
           && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 chk(nm, qa.size() + qb.size() + qc.size() + qd.size() + qe.size() + qf.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence
  initial begin
    rst_n = 1'b0;
    a_data = '0; a_iv = 0; a_ordy = 1; a_sc = 0;
    b_data = '0; b_iv = 0; b_ordy_m = 1; b_rand = 0; b_sc = 0;
    x_data = '0; x_iv = 0; x_ordy = 1; x_sc = 0;
    y_data = '0; y_iv = 0; y_ordy = 1; y_sc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_out_valid", a_ov, 0);
    chk("rst_a_in_ready", a_ir, 1);
    chk("rst_a_result", a_res, 0);
    chk("rst_a_overflow", a_ovf, 0);
    chk("rst_a_sticky", a_st, 0);
    chk("rst_b_out_valid", b_ov, 0);
    chk("rst_c_result", c_res, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: plain magnitudes, back to back
    send_a(8'd5,   8'd5,   1'b0);
    send_a(8'hFB,  8'd5,   1'b0);
    send_a(8'd0,   8'd0,   1'b0);
    send_a(8'd127, 8'd127, 1'b0);
    send_a(8'h81,  8'd127, 1'b0);
    // T2 wrap: most-negative input
    send_a(8'h80, 8'h80, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("a_sticky_after_ovf", a_st, 1);

    // T5: clear alone, then set and clear together, then clear alone
    a_sc = 1'b1;
    @(posedge clk);
    #1 a_sc = 1'b0;
    chk("a_sticky_clr", a_st, 0);
    send_a(8'h80, 8'h80, 1'b1);
    @(posedge clk);
    #1 chk("a_ovf_pending", a_ov, 1);
    chk("a_ovf_pending_flag", a_ovf, 1);
    a_sc = 1'b1;
    @(posedge clk);
    #1 a_sc = 1'b0;
    chk("a_sticky_set_wins", a_st, 1);
    a_sc = 1'b1;
    @(posedge clk);
    #1 a_sc = 1'b0;
    chk("a_sticky_clr2", a_st, 0);

    // T2 saturate: stalled overflow must not set sticky until it transfers
    b_ordy_m = 1'b0;
    send_b(8'h80, 8'h7F, 1'b1);
    repeat (4) @(posedge clk);
    #1 chk("b_ovf_held_valid", b_ov, 1);
    chk("b_sticky_while_stalled", b_st, 0);
    b_ordy_m = 1'b1;
    @(posedge clk);
    #1 chk("b_sticky_after_xfer", b_st, 1);

    // T4: counting stream under random backpressure
    b_rand = 1'b1;
    for (int i = 1; i <= 20; i++) send_b(8'(i), 8'(i), 1'b0);
    drain("drain_t4");
    b_rand = 1'b0;

    // T3: four 4-bit channels, wrap and saturate side by side
    send_x(16'h8F7D, 16'h8173, 16'h7173, 4'b1000);
    send_x(16'h0958, 16'h0758, 16'h0757, 4'b0001);
    send_x(16'h1234, 16'h1234, 16'h1234, 4'b0000);
    // W=1 corner: ch1=1 (most negative), ch0=0, then swapped
    send_y(2'b10, 2'b10, 2'b00, 2'b10);
    send_y(2'b01, 2'b01, 2'b00, 2'b01);
    send_y(2'b00, 2'b00, 2'b00, 2'b00);
    drain("drain_t3");
    chk("c_sticky", c_st, 4'b1001);
    chk("d_sticky", d_st, 4'b1001);
    chk("e_sticky", e_st, 2'b11);

    // T6: reset with three samples in flight in B
    b_ordy_m = 1'b0;
    send_b(8'd1, 8'd1, 1'b0);
    send_b(8'd2, 8'd2, 1'b0);
    send_b(8'd3, 8'd3, 1'b0);
    chk("b_full_out_valid", b_ov, 1);
    chk("b_full_in_ready", b_ir, 0);
    rst_n = 1'b0;
    #1 chk("b_reset_out_valid", b_ov, 0);
    chk("b_reset_sticky", b_st, 0);
    chk("a_reset_sticky", a_st, 0);
    qb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    b_ordy_m = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("b_no_stale_output", b_ov, 0);
    chk("b_ready_after_reset", b_ir, 1);
    send_b(8'h9C, 8'd100, 1'b0);
    drain("drain_t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
